// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a small write FIFO for the MIPS store path.
// Bytes are serialised LSB first on a registered tx line; status flags support polling.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          push, pop;

  state_t        state_q, state_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  // Flags come from the registered count, so a write while full is dropped
  // even when a pop happens on the same edge.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign push       = wr_en && !fifo_full;

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;

  // NOTE: the payload array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      else if (clr_ovf)       ovf_q <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        // Registered done rises one cycle early so it is high during the final stop cycle.
        if (baud_q == BAUD_PRE) done_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule
